// File: rtl/vec_reg_file_if.sv
// Write, read and stream-out signals of the vector register file.
// The master side drives writes, selects and stream control; the slave side is the register file.
interface vec_reg_file_if #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int WIDTH_ADDR_SIZE = $clog2(WIDTH);
    localparam int ADDR_SIZE       = $clog2(DEPTH);

    logic [1:0]                 write_op;
    logic [ADDR_SIZE-1:0]       write_addr;
    logic [WIDTH_ADDR_SIZE-1:0] write_param;
    logic [WIDTH-1:0]           write_mask;
    logic [DATA_WIDTH-1:0]      data_in [WIDTH-1:0];
    logic [ADDR_SIZE-1:0]       read_addr;
    logic [DATA_WIDTH-1:0]      data_out [WIDTH-1:0];

    logic                       stream_start;
    logic [ADDR_SIZE-1:0]       stream_addr;
    logic                       stream_ready;
    logic                       stream_valid;
    logic [DATA_WIDTH-1:0]      stream_data;
    logic [WIDTH_ADDR_SIZE-1:0] stream_lane;
    logic                       stream_last;
    logic                       stream_busy;

    modport master (
        output write_op, write_addr, write_param, write_mask, data_in, read_addr,
        output stream_start, stream_addr, stream_ready,
        input  data_out, stream_valid, stream_data, stream_lane, stream_last, stream_busy
    );

    modport slave (
        input  write_op, write_addr, write_param, write_mask, data_in, read_addr,
        input  stream_start, stream_addr, stream_ready,
        output data_out, stream_valid, stream_data, stream_lane, stream_last, stream_busy
    );
endinterface

// File: rtl/vec_reg_file.sv
// DEPTH x WIDTH vector register file: four write modes, a combinational full-vector
// read port and a lane-serial valid/ready stream-out port reading live storage.
module vec_reg_file #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    vec_reg_file_if.slave     bus
);
    localparam int WIDTH_ADDR_SIZE = $clog2(WIDTH);
    localparam int ADDR_SIZE       = $clog2(DEPTH);
    localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_LANE = WIDTH_ADDR_SIZE'(WIDTH - 1);

    typedef enum logic [1:0] {WR_DISABLE, WR_VEC, WR_SCALAR, WR_BCAST} wr_op_e;
    typedef enum logic {IDLE, STREAM} state_e;

    wr_op_e                     wr_op;
    state_e                     state_q, state_d;
    logic [WIDTH_ADDR_SIZE-1:0] lane_q, lane_d;
    logic [ADDR_SIZE-1:0]       str_reg_q, str_reg_d;
    logic [DATA_WIDTH-1:0]      strm_col [WIDTH];

    assign wr_op = wr_op_e'(bus.write_op);

    // Storage is organised lane-major: each lane owns a column of DEPTH cells and
    // exposes both the read-port word and the word of the register being streamed.
    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        logic                  lane_we;
        logic [DATA_WIDTH-1:0] lane_wd;
        logic [DATA_WIDTH-1:0] col [DEPTH];

        always_comb begin
            lane_we = 1'b0;
            lane_wd = bus.data_in[0];
            case (wr_op)
                WR_VEC: begin
                    lane_we = bus.write_mask[l];
                    lane_wd = bus.data_in[l];
                end
                WR_SCALAR: lane_we = (bus.write_param == WIDTH_ADDR_SIZE'(l));
                WR_BCAST:  lane_we = 1'b1;
                default:   lane_we = 1'b0;
            endcase
        end

        for (genvar r = 0; r < DEPTH; r++) begin : g_reg
            logic [DATA_WIDTH-1:0] cell_q;

            always_ff @(posedge clock_i) begin
                if (reset_i)
                    cell_q <= '0;
                else if (lane_we && bus.write_addr == ADDR_SIZE'(r))
                    cell_q <= lane_wd;
            end

            assign col[r] = cell_q;
        end

        assign bus.data_out[l] = col[bus.read_addr];
        assign strm_col[l]     = col[str_reg_q];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            str_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            str_reg_q <= str_reg_d;
        end
    end

    // stream_start is only looked at in IDLE, so a pulse during the final transfer is dropped.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        str_reg_d = str_reg_q;
        case (state_q)
            IDLE: begin
                if (bus.stream_start) begin
                    state_d   = STREAM;
                    lane_d    = '0;
                    str_reg_d = bus.stream_addr;
                end
            end
            STREAM: begin
                if (bus.stream_ready) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = IDLE;
                        lane_d  = '0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.stream_valid = (state_q == STREAM);
        bus.stream_busy  = (state_q == STREAM);
        bus.stream_lane  = (state_q == STREAM) ? lane_q : '0;
        bus.stream_last  = (state_q == STREAM) && (lane_q == LAST_LANE);
        bus.stream_data  = (state_q == STREAM) ? strm_col[lane_q] : '0;
    end
endmodule

// File: tb/tb_vec_reg_file.sv
// Directed bench for vec_reg_file at WIDTH=8, DEPTH=8: write modes, read port,
// streaming with stalls, mid-stream writes and mid-stream reset.
module tb_vec_reg_file;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vec_reg_file_if #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) bus ();

    vec_reg_file #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_op     = 2'd0;
        bus.write_addr   = '0;
        bus.write_param  = '0;
        bus.write_mask   = '0;
        for (int i = 0; i < W; i++) bus.data_in[i] = '0;
        bus.read_addr    = '0;
        bus.stream_start = 1'b0;
        bus.stream_addr  = '0;
        bus.stream_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.stream_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b exp 0", bus.stream_valid); end
        checks++; if (bus.stream_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b exp 0", bus.stream_busy); end
        checks++; if (bus.stream_last !== 1'b0) begin errs++; $display("FAIL reset_last: got %b exp 0", bus.stream_last); end
        checks++; if (bus.stream_lane !== '0) begin errs++; $display("FAIL reset_lane: got %0d exp 0", bus.stream_lane); end
        checks++; if (bus.stream_data !== '0) begin errs++; $display("FAIL reset_sdata: got %h exp 0", bus.stream_data); end
        for (int r = 0; r < D; r++) begin
            bus.read_addr = 3'(r);
            #1;
            for (int i = 0; i < W; i++) begin
                checks++;
                if (bus.data_out[i] !== '0) begin errs++; $display("FAIL reset_dout r%0d l%0d: got %h exp 0", r, i, bus.data_out[i]); end
            end
        end
    endtask

    task automatic test_vec_full();
        bus.write_op   = 2'd1;
        bus.write_addr = 3'd3;
        bus.write_mask = '1;
        for (int i = 0; i < W; i++) bus.data_in[i] = 32'(i);
        bus.read_addr  = 3'd3;
        #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.data_out[i] !== '0) begin errs++; $display("FAIL vec_no_bypass l%0d: got %h exp 0", i, bus.data_out[i]); end
        end
        step();
        bus.write_op = 2'd0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.data_out[i] !== 32'(i)) begin errs++; $display("FAIL vec_full l%0d: got %h exp %h", i, bus.data_out[i], 32'(i)); end
        end
    endtask

    task automatic test_vec_mask_scalar();
        logic [DW-1:0] exp_v [W];
        bus.write_op   = 2'd1;
        bus.write_addr = 3'd1;
        bus.write_mask = '1;
        for (int i = 0; i < W; i++) begin bus.data_in[i] = 32'h100 + 32'(i); exp_v[i] = 32'h100 + 32'(i); end
        step();
        bus.write_mask = 8'h05;
        for (int i = 0; i < W; i++) bus.data_in[i] = 32'hAA;
        exp_v[0] = 32'hAA;
        exp_v[2] = 32'hAA;
        step();
        bus.write_op  = 2'd0;
        bus.read_addr = 3'd1;
        #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.data_out[i] !== exp_v[i]) begin errs++; $display("FAIL vec_mask l%0d: got %h exp %h", i, bus.data_out[i], exp_v[i]); end
        end
        bus.write_op    = 2'd2;
        bus.write_param = 3'(W - 1);
        bus.write_mask  = '1;
        for (int i = 0; i < W; i++) bus.data_in[i] = 32'hDEAD0000 + 32'(i);
        bus.data_in[0]  = 32'h3F800000;
        exp_v[W-1]      = 32'h3F800000;
        step();
        bus.write_op = 2'd0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.data_out[i] !== exp_v[i]) begin errs++; $display("FAIL scalar l%0d: got %h exp %h", i, bus.data_out[i], exp_v[i]); end
        end
    endtask

    task automatic test_broadcast();
        bus.write_op   = 2'd3;
        bus.write_addr = 3'(D - 1);
        bus.write_mask = '0;
        for (int i = 0; i < W; i++) bus.data_in[i] = 32'h11;
        bus.data_in[0] = 32'h40490FDB;
        step();
        bus.write_op  = 2'd0;
        bus.read_addr = 3'(D - 1);
        #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.data_out[i] !== 32'h40490FDB) begin errs++; $display("FAIL bcast l%0d: got %h exp 40490fdb", i, bus.data_out[i]); end
        end
        bus.read_addr = 3'd6;
        #1;
        checks++;
        if (bus.data_out[0] !== '0) begin errs++; $display("FAIL bcast_neighbor: got %h exp 0", bus.data_out[0]); end
    endtask

    task automatic test_stream();
        bus.stream_start = 1'b1;
        bus.stream_addr  = 3'd3;
        bus.stream_ready = 1'b1;
        step();
        for (int k = 0; k < W; k++) begin
            checks++; if (bus.stream_valid !== 1'b1) begin errs++; $display("FAIL stream_valid k%0d: got %b exp 1", k, bus.stream_valid); end
            checks++; if (bus.stream_busy !== 1'b1) begin errs++; $display("FAIL stream_busy k%0d: got %b exp 1", k, bus.stream_busy); end
            checks++; if (bus.stream_lane !== 3'(k)) begin errs++; $display("FAIL stream_lane k%0d: got %0d exp %0d", k, bus.stream_lane, k); end
            checks++; if (bus.stream_data !== 32'(k)) begin errs++; $display("FAIL stream_data k%0d: got %h exp %h", k, bus.stream_data, 32'(k)); end
            checks++; if (bus.stream_last !== (k == W - 1)) begin errs++; $display("FAIL stream_last k%0d: got %b exp %b", k, bus.stream_last, k == W - 1); end
            bus.stream_start = (k == 3) || (k == W - 1);
            bus.stream_addr  = 3'd1;
            step();
        end
        bus.stream_start = 1'b0;
        checks++; if (bus.stream_valid !== 1'b0) begin errs++; $display("FAIL stream_end_valid: got %b exp 0", bus.stream_valid); end
        checks++; if (bus.stream_busy !== 1'b0) begin errs++; $display("FAIL stream_end_busy: got %b exp 0", bus.stream_busy); end
        checks++; if (bus.stream_last !== 1'b0) begin errs++; $display("FAIL stream_end_last: got %b exp 0", bus.stream_last); end
        step();
        checks++; if (bus.stream_valid !== 1'b0) begin errs++; $display("FAIL stream_final_start_ignored: got %b exp 0", bus.stream_valid); end
    endtask

    task automatic test_stall_write();
        logic [DW-1:0] exp_v [W];
        int  exp_lane = 0;
        int  cyc = 0;
        bit  done_wr = 0;
        bit  rdy;
        bit  wr;
        for (int i = 0; i < W; i++) exp_v[i] = 32'(i);
        bus.stream_start = 1'b1;
        bus.stream_addr  = 3'd3;
        bus.stream_ready = 1'b0;
        step();
        bus.stream_start = 1'b0;
        while (exp_lane < W && cyc < 64) begin
            checks++; if (bus.stream_valid !== 1'b1) begin errs++; $display("FAIL stall_valid c%0d: got %b exp 1", cyc, bus.stream_valid); end
            checks++; if (bus.stream_lane !== 3'(exp_lane)) begin errs++; $display("FAIL stall_lane c%0d: got %0d exp %0d", cyc, bus.stream_lane, exp_lane); end
            checks++; if (bus.stream_data !== exp_v[exp_lane]) begin errs++; $display("FAIL stall_data c%0d: got %h exp %h", cyc, bus.stream_data, exp_v[exp_lane]); end
            rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            wr  = !rdy && (exp_lane == 3) && !done_wr;
            bus.stream_ready = rdy;
            if (wr) begin
                bus.write_op    = 2'd2;
                bus.write_addr  = 3'd3;
                bus.write_param = 3'd3;
                bus.data_in[0]  = 32'h77;
                done_wr = 1;
            end else begin
                bus.write_op = 2'd0;
            end
            step();
            if (wr) exp_v[3] = 32'h77;
            if (rdy) exp_lane++;
            cyc++;
        end
        bus.write_op     = 2'd0;
        bus.stream_ready = 1'b0;
        checks++; if (exp_lane != W) begin errs++; $display("FAIL stall_timeout: got %0d lanes exp %0d", exp_lane, W); end
        checks++; if (done_wr != 1) begin errs++; $display("FAIL stall_write_issued: got %0d exp 1", done_wr); end
        checks++; if (bus.stream_valid !== 1'b0) begin errs++; $display("FAIL stall_end_valid: got %b exp 0", bus.stream_valid); end
    endtask

    task automatic test_reset_mid_stream();
        bus.stream_start = 1'b1;
        bus.stream_addr  = 3'd3;
        bus.stream_ready = 1'b1;
        step();
        bus.stream_start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        checks++; if (bus.stream_lane !== 3'd5) begin errs++; $display("FAIL mid_lane5: got %0d exp 5", bus.stream_lane); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.stream_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b exp 0", bus.stream_valid); end
        checks++; if (bus.stream_busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b exp 0", bus.stream_busy); end
        for (int r = 0; r < D; r++) begin
            bus.read_addr = 3'(r);
            #1;
            for (int i = 0; i < W; i++) begin
                checks++;
                if (bus.data_out[i] !== '0) begin errs++; $display("FAIL mid_rst_dout r%0d l%0d: got %h exp 0", r, i, bus.data_out[i]); end
            end
        end
        bus.stream_start = 1'b1;
        bus.stream_addr  = 3'd3;
        step();
        bus.stream_start = 1'b0;
        for (int k = 0; k < W; k++) begin
            checks++; if (bus.stream_lane !== 3'(k)) begin errs++; $display("FAIL zero_stream_lane k%0d: got %0d exp %0d", k, bus.stream_lane, k); end
            checks++; if (bus.stream_valid !== 1'b1 || bus.stream_data !== '0) begin errs++; $display("FAIL zero_stream_data k%0d: got v=%b d=%h exp v=1 d=0", k, bus.stream_valid, bus.stream_data); end
            step();
        end
        checks++; if (bus.stream_busy !== 1'b0) begin errs++; $display("FAIL zero_stream_end: got %b exp 0", bus.stream_busy); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_vec_full();
        test_vec_mask_scalar();
        test_broadcast();
        test_stream();
        test_stall_write();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/vec_reg_file.md
# vec_reg_file

Parametrised vector register file with DEPTH vector registers of WIDTH lanes each, and four write modes: full vector, lane-masked vector, single-lane scalar and broadcast. It provides one zero-latency full-vector read port and a lane-serial stream-out port with a valid/ready handshake. The stream port feeds scalar consumers such as the reduction unit or the memory writer. It is the multi-register successor of the single vector register in the vector unit datapath.

## Interface
- WIDTH, 128, lanes per vector; power of two, ≥2
- DEPTH, 8, number of vector registers; power of two, ≥2
- DATA_WIDTH, 32, bits per lane (IEEE-754 single, opaque to this block)
- WIDTH_ADDR_SIZE, $clog2(WIDTH), lane index width
- ADDR_SIZE, $clog2(DEPTH), register index width

- clock  in  1  sole clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- write_op  in  2  0 DISABLE, 1 VEC, 2 SCALAR, 3 BROADCAST
- write_addr  in  ADDR_SIZE  destination register
- write_param  in  WIDTH_ADDR_SIZE  target lane for SCALAR
- write_mask  in  WIDTH  per-lane enable for VEC (bit i gates lane i)
- data_in  in  WIDTH x DATA_WIDTH  write data, unpacked [WIDTH-1:0]
- read_addr  in  ADDR_SIZE  read port register select
- data_out  out  WIDTH x DATA_WIDTH  contents of register read_addr
- stream_start  in  1  request serial read-out of register stream_addr
- stream_addr  in  ADDR_SIZE  register to stream, sampled with stream_start
- stream_ready  in  1  consumer accepts current lane
- stream_valid  out  1  stream_data holds a lane
- stream_data  out  DATA_WIDTH  current lane value
- stream_lane  out  WIDTH_ADDR_SIZE  index of current lane
- stream_last  out  1  current lane is WIDTH-1
- stream_busy  out  1  stream FSM not IDLE

## Operation
- Storage: DEPTH x WIDTH x DATA_WIDTH. Reset clears all storage to 0.
- Write modes:
  - DISABLE: no change.
  - VEC: mem[write_addr][i] <= data_in[i] for every i with write_mask[i]=1. An all-ones mask is a full write; an all-zeros mask is a no-op.
  - SCALAR: mem[write_addr][write_param] <= data_in[0]. Other lanes are unchanged. write_mask is ignored.
  - BROADCAST: mem[write_addr][i] <= data_in[0] for all i. write_mask is ignored.
- Read port: data_out = mem[read_addr]. Combinational, no op select.
- Stream FSM states: IDLE, STREAM.
  - IDLE: if stream_start=1, latch stream_addr into str_reg, set lane counter to 0, go to STREAM.
  - STREAM:
    - stream_valid=1.
    - stream_data = mem[str_reg][lane], read from live storage.
    - A transfer occurs when stream_valid & stream_ready. Each transfer increments lane.
    - A transfer with lane=WIDTH-1 returns the FSM to IDLE.
    - stream_start is ignored in STREAM, including in the final-transfer cycle.
- Streaming and writing are independent. A write to the lane being streamed is visible on stream_data the cycle after the write edge. Lanes already transferred are not re-sent.

## Timing
- Reset values:
  - storage 0; FSM IDLE; lane 0; str_reg 0
  - stream_valid 0, stream_busy 0, stream_last 0, stream_lane 0, stream_data 0
  - data_out 0, since storage is 0
- Write latency 1: data written at edge N appears on data_out/stream_data after edge N. A same-cycle read of the written address returns the old value (no bypass).
- Stream start latency 1: stream_start high in the cycle before edge N means stream_valid=1 with lane 0 after edge N.
- stream_busy == stream_valid == (state==STREAM).
- stream_lane and stream_last are valid only when stream_valid=1. They are 0 in IDLE.
- Throughput is 1 lane/cycle with stream_ready held high. A full vector takes WIDTH cycles, then stream_valid=0 in the following cycle.
- With stream_ready low, stream_data and stream_lane hold. stream_data changes only if that lane is written.
- Reset asserted mid-stream: FSM goes to IDLE and storage clears at that edge. There is no partial-transfer indication.
- A new stream can start at the earliest one cycle after stream_busy falls, i.e. stream_start sampled while IDLE.

## Test plan
- Reset, then write VEC mask all-ones data_in[i]=i to reg 3, read_addr=3 → data_out[i]=i next cycle. Previous-cycle read shows 0.
- VEC to reg 1 with mask=0x...0005, data 0xAA → only lanes 0 and 2 are 0xAA, others keep prior values. SCALAR write_param=WIDTH-1 data_in[0]=0x3F800000 → only the last lane changes.
- BROADCAST reg 7 data_in[0]=0x40490FDB → all WIDTH lanes equal 0x40490FDB. Also checks write_addr=DEPTH-1 boundary.
- Stream reg 3 (data i) with stream_ready=1 → stream_valid for exactly WIDTH cycles, stream_lane/stream_data 0..WIDTH-1, stream_last only on the final lane, busy falls the next cycle. A stream_start pulse mid-stream is ignored.
- Stream with stream_ready toggling 1,0,0,1,… plus a SCALAR write to the current stalled lane → data holds during stall, shows the new value one cycle after the write, and no lane is dropped or duplicated.
- Assert reset at lane 5 of a stream → after the edge stream_valid=0, stream_busy=0, data_out of every register is 0. A new stream_start then streams zeros from lane 0.
